// File: rtl/ram_pkg.sv
// Shared types and constants for the ram_master requester and its RAM.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Cycles between presenting a RAM address and MEM_DOUT carrying its word.
  localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/ram_master_if.sv
// Request and RAM-port bundle for ram_master; `master` is the controller view,
// `slave` is the environment (CPU datapath plus RAM) view.
interface ram_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 8
);
  // Handshake: REQ (with WE/REQ_ADDR/LEN/WR_DATA) is consumed on any rising
  // edge where BUSY is low; while BUSY is high REQ is dropped, never queued.
  // RD_VALID qualifies RD_DATA for one cycle; DONE pulses once per accepted request.
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] len;
  logic [WIDTH-1:0]      wr_data;
  logic                  busy;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;
  logic                  done;
  logic                  mem_ce;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_din;
  logic [WIDTH-1:0]      mem_dout;

  modport master (
    input  req, we, req_addr, len, wr_data, mem_dout,
    output busy, rd_data, rd_valid, done, mem_ce, mem_addr, mem_din
  );

  modport slave (
    output req, we, req_addr, len, wr_data, mem_dout,
    input  busy, rd_data, rd_valid, done, mem_ce, mem_addr, mem_din
  );
endinterface

// File: rtl/ram_master.sv
// Requester-side controller for a single-port synchronous RAM: single writes,
// pipelined burst reads. Burst length is honoured only with RAM_MASTER_BURST_EN.
module ram_master
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_master_if.master   bus,
  output state_e         dbg_state_o
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        din_q, din_d;
  logic                    ce_q, ce_d;
  logic                    done_q, done_d;
  logic [WIDTH-1:0]        rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [RAM_RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;
  logic [RAM_RD_LAT-1:0]   last_pipe_q, last_pipe_d;
  logic                    rd_issue;
  logic                    beat_last;

`ifdef RAM_MASTER_BURST_EN
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

  // cnt_q holds the beats still to issue after the current one.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && bus.req && !bus.we) begin
      cnt_d = bus.len;
    end else if (state_q == READ && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign beat_last = (cnt_q == '0);
`else
  logic unused_len;
  assign unused_len = ^bus.len;
  assign beat_last  = 1'b1;
`endif

  assign rd_issue = (state_q == READ);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    din_d       = din_q;
    ce_d        = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = vld_pipe_q[RAM_RD_LAT-1];
    done_d      = (state_q == WRITE) | last_pipe_q[RAM_RD_LAT-1];
    vld_pipe_d  = '0;
    last_pipe_d = '0;

    // Valid/last markers travel alongside the RAM read latency.
    vld_pipe_d[0]  = rd_issue;
    last_pipe_d[0] = rd_issue & beat_last;
    for (int i = 1; i < RAM_RD_LAT; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end

    if (vld_pipe_q[RAM_RD_LAT-1]) rd_data_d = bus.mem_dout;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d = bus.req_addr;
          if (bus.we) begin
            state_d = WRITE;
            ce_d    = 1'b1;
            din_d   = bus.wr_data;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        if (beat_last) state_d = DRAIN;
        else           addr_d  = addr_q + 1'b1;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      din_q       <= '0;
      ce_q        <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      ce_q        <= ce_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.done     = done_q;
  assign bus.mem_ce   = ce_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master with an inline one-cycle-latency RAM model.
module tb_ram_master;
  import ram_pkg::*;

`ifdef RAM_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  ram_master_if #(.ADDR_WIDTH(4), .WIDTH(8)) bus ();

  ram_master #(.ADDR_WIDTH(4), .WIDTH(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: write on CE, registered read of the presented address
  logic [7:0] mem_model [16];
  always @(posedge clk) begin
    if (bus.mem_ce) mem_model[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem_model[bus.mem_addr];
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] shadow [16];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic start_req(input bit we, input logic [3:0] a, input logic [3:0] l,
                           input logic [7:0] d);
    @(negedge clk);
    bus.req      = 1'b1;
    bus.we       = we;
    bus.req_addr = a;
    bus.len      = l;
    bus.wr_data  = d;
    @(posedge clk);
    #1;
    bus.req      = 1'b0;
    bus.we       = 1'($urandom_range(0, 1));
    bus.req_addr = 4'($urandom_range(0, 15));
    bus.len      = 4'($urandom_range(0, 15));
    bus.wr_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic do_write(input string tag, input logic [3:0] a, input logic [7:0] d);
    start_req(1'b1, a, 4'd0, d);
    check({tag, "_busy_c1"}, bus.busy, 1);
    check({tag, "_ce_c1"}, bus.mem_ce, 1);
    check({tag, "_addr_c1"}, bus.mem_addr, a);
    check({tag, "_din_c1"}, bus.mem_din, d);
    check({tag, "_done_c1"}, bus.done, 0);
    @(posedge clk);
    #1;
    check({tag, "_done_c2"}, bus.done, 1);
    check({tag, "_busy_c2"}, bus.busy, 0);
    check({tag, "_ce_c2"}, bus.mem_ce, 0);
    shadow[a] = d;
  endtask

  task automatic do_read(input string tag, input logic [3:0] a, input logic [3:0] l,
                         input bit inject);
    int nb;
    int c;
    int beat;
    bit got_done;
    logic [3:0] wa;
    nb = BURST ? int'(l) + 1 : 1;
    for (int i = 0; i < nb; i++) begin
      wa = a + 4'(i);
      exp_q.push_back(shadow[wa]);
    end
    start_req(1'b0, a, l, 8'($urandom_range(0, 255)));
    c = 1;
    beat = 0;
    got_done = 1'b0;
    check({tag, "_busy_c1"}, bus.busy, 1);
    check({tag, "_addr_c1"}, bus.mem_addr, a);
    check({tag, "_ce_c1"}, bus.mem_ce, 0);
    while (!got_done && c < nb + 10) begin
      if (inject && c == 1) begin
        bus.req      = 1'b1;
        bus.we       = 1'b1;
        bus.req_addr = 4'd0;
        bus.wr_data  = 8'hFF;
      end
      @(posedge clk);
      #1;
      c++;
      if (inject && c == 3) bus.req = 1'b0;
      check({tag, "_ce"}, bus.mem_ce, 0);
      if (bus.rd_valid === 1'b1) begin
        if (exp_q.size() > 0) begin
          check({tag, "_data"}, bus.rd_data, exp_q.pop_front());
          check({tag, "_beat_cycle"}, c, 3 + beat);
        end else begin
          check({tag, "_extra_beat"}, 1, 0);
        end
        beat++;
      end
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
        check({tag, "_done_cycle"}, c, nb + 2);
        check({tag, "_done_with_valid"}, bus.rd_valid, 1);
        check({tag, "_beats"}, beat, nb);
        check({tag, "_busy_at_done"}, bus.busy, 0);
      end
    end
    check({tag, "_done_timeout"}, got_done, 1);
    exp_q.delete();
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.req      = 1'b0;
    bus.we       = 1'b0;
    bus.req_addr = '0;
    bus.len      = '0;
    bus.wr_data  = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.rd_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_ce", bus.mem_ce, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_din", bus.mem_din, 0);
    check("rst_rdata", bus.rd_data, 0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // single write then read
    do_write("wr_a5", 4'd3, 8'hA5);
    do_read("rd_a5", 4'd3, 4'd0, 1'b0);

    // preload MEM[i] = i + 0x10
    for (int i = 0; i < 16; i++) do_write("preload", 4'(i), 8'(i + 16));

    // burst read with wrap: 0x1E, 0x1F, 0x10, 0x11
    do_read("wrap", 4'd14, 4'd3, 1'b0);

    // full-memory sweep
    do_read("sweep", 4'd0, 4'd15, 1'b0);

    // REQ while busy is dropped
    do_read("ignore", 4'd4, 4'd3, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("ignore_no_done", bus.done, 0);
      check("ignore_no_ce", bus.mem_ce, 0);
    end
    do_read("ignore_mem0", 4'd0, 4'd0, 1'b0);

    // back-to-back: read, write in its DONE cycle, read in the write's DONE cycle
    do_read("b2b_rd1", 4'd7, 4'd1, 1'b0);
    do_write("b2b_wr", 4'd7, 8'h5C);
    do_read("b2b_rd2", 4'd7, 4'd0, 1'b0);

    // reset in cycle 4 of an 8-beat read
    start_req(1'b0, 4'd0, 4'd7, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.rd_valid, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_ce", bus.mem_ce, 0);
    check("mid_rst_addr", bus.mem_addr, 0);
    check("mid_rst_rdata", bus.rd_data, 0);
    check("mid_rst_state", dbg_state, IDLE);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("mid_rst_hold_done", bus.done, 0);
      check("mid_rst_hold_valid", bus.rd_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post_rst_done", bus.done, 0);
      check("post_rst_valid", bus.rd_valid, 0);
      check("post_rst_state", dbg_state, IDLE);
    end
    do_read("post_rst_rd", 4'd5, 4'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
